// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if -- command/status and memory-address bundle of the NTT
// sequencer. The host drives the command side (master); ntt_ctrl drives the
// status, read-address, write-address and mode outputs (slave).
interface ntt_ctrl_if;
    // Command from host
    logic       start_i;
    logic       sel_red_i;
    logic       sel_butterfly_i;

    // Status back to host
    logic       busy_o;
    logic       done_o;

    // Coefficient-pair read request and matching twiddle ROM index
    logic       rd_en_o;
    logic [7:0] rd_addr_a_o;
    logic [7:0] rd_addr_b_o;
    logic [7:0] twiddle_idx_o;

    // Write-back of butterfly results
    logic       wr_en_o;
    logic [7:0] wr_addr_a_o;
    logic [7:0] wr_addr_b_o;

    // Mode bits held for the butterfly during a transform
    logic       sel_red_o;
    logic       sel_butterfly_o;

    modport master (
        output start_i, sel_red_i, sel_butterfly_i,
        input  busy_o, done_o,
        input  rd_en_o, rd_addr_a_o, rd_addr_b_o, twiddle_idx_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o,
        input  sel_red_o, sel_butterfly_o
    );

    modport slave (
        input  start_i, sel_red_i, sel_butterfly_i,
        output busy_o, done_o,
        output rd_en_o, rd_addr_a_o, rd_addr_b_o, twiddle_idx_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o,
        output sel_red_o, sel_butterfly_o
    );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl -- address/twiddle sequencer for a 256-point in-place NTT.
// Kyber (7 layers) or Dilithium (8 layers), forward Cooley-Tukey or inverse
// Gentleman-Sande. One butterfly pair is issued per cycle; write-back
// addresses follow the read addresses after the butterfly latency D.
// Build option: define NTT_CTRL_OUT_REG_EN for a registered butterfly
// output stage (D = 2); otherwise D = 1.
// n^-1 scaling after the inverse transform is left to the datapath.
module ntt_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    ntt_ctrl_if.slave    bus
);

`ifdef NTT_CTRL_OUT_REG_EN
    localparam int unsigned D = 2;
`else
    localparam int unsigned D = 1;
`endif

    // Last DRAIN cycle index (drain counter runs 0..D-1)
    localparam logic [1:0] DRAIN_LAST = 2'(D - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // First layer's half-distance: forward always starts at 128,
    // inverse starts at 2 (Kyber) or 1 (Dilithium).
    function automatic logic [7:0] first_len(input logic red, input logic inv);
        logic [7:0] len;
        if (!inv) begin
            len = 8'd128;
        end else if (red) begin
            len = 8'd2;
        end else begin
            len = 8'd1;
        end
        return len;
    endfunction

    // First twiddle index: forward counts up from 1, inverse counts down
    // from the last index used by the forward transform.
    function automatic logic [7:0] first_k(input logic red, input logic inv);
        logic [7:0] k;
        if (!inv) begin
            k = 8'd1;
        end else if (red) begin
            k = 8'd127;
        end else begin
            k = 8'd255;
        end
        return k;
    endfunction

    // FSM and registered read-side outputs
    state_t     state_q;
    logic       busy_q;
    logic       done_q;
    logic       rd_en_q;
    logic [7:0] rd_addr_a_q;
    logic [7:0] rd_addr_b_q;
    logic [7:0] twiddle_q;
    logic       sel_red_q;
    logic       sel_butterfly_q;
    logic [7:0] len_q;      // current layer's len (next layer's once in DRAIN)
    logic [7:0] cnt_q;      // pairs issued so far in the current layer
    logic [2:0] layer_q;    // current layer index
    logic [1:0] drain_q;    // cycles spent in DRAIN

    // Write pipeline
    logic       wr_en_q;
    logic [7:0] wr_addr_a_q;
    logic [7:0] wr_addr_b_q;
`ifdef NTT_CTRL_OUT_REG_EN
    logic       wr1_en_q;
    logic [7:0] wr1_addr_a_q;
    logic [7:0] wr1_addr_b_q;
`endif

    // Next-pair arithmetic
    logic [7:0] j_inc_d;
    logic [7:0] pair_j_d;
    logic [7:0] pair_k_d;
    logic [7:0] k_step_d;
    logic [7:0] len_next_d;
    logic [2:0] last_layer_s;

    // Next pair within a layer: j advances by one; when j+1 enters the
    // upper half of a group (bit 'len' set) the group is finished, so skip
    // the upper half and step the twiddle index.
    always_comb begin
        j_inc_d      = rd_addr_a_q + 8'd1;
        k_step_d     = sel_butterfly_q ? (twiddle_q - 8'd1) : (twiddle_q + 8'd1);
        len_next_d   = sel_butterfly_q ? (len_q << 1) : (len_q >> 1);
        last_layer_s = sel_red_q ? 3'd6 : 3'd7;
        if ((j_inc_d & len_q) != 8'd0) begin
            pair_j_d = j_inc_d + len_q;
            pair_k_d = k_step_d;
        end else begin
            pair_j_d = j_inc_d;
            pair_k_d = twiddle_q;
        end
    end

    // Sequencer FSM: IDLE -> ISSUE (128 pairs) -> DRAIN (D cycles) -> ... -> DONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            rd_en_q         <= 1'b0;
            rd_addr_a_q     <= 8'd0;
            rd_addr_b_q     <= 8'd0;
            twiddle_q       <= 8'd0;
            sel_red_q       <= 1'b0;
            sel_butterfly_q <= 1'b0;
            len_q           <= 8'd0;
            cnt_q           <= 8'd0;
            layer_q         <= 3'd0;
            drain_q         <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_q         <= ST_ISSUE;
                        busy_q          <= 1'b1;
                        sel_red_q       <= bus.sel_red_i;
                        sel_butterfly_q <= bus.sel_butterfly_i;
                        len_q           <= first_len(bus.sel_red_i, bus.sel_butterfly_i);
                        twiddle_q       <= first_k(bus.sel_red_i, bus.sel_butterfly_i);
                        rd_en_q         <= 1'b1;
                        rd_addr_a_q     <= 8'd0;
                        rd_addr_b_q     <= first_len(bus.sel_red_i, bus.sel_butterfly_i);
                        cnt_q           <= 8'd1;
                        layer_q         <= 3'd0;
                        drain_q         <= 2'd0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt_q == 8'd128) begin
                        // Layer finished: stop reading, prepare next layer
                        state_q   <= ST_DRAIN;
                        rd_en_q   <= 1'b0;
                        len_q     <= len_next_d;
                        twiddle_q <= k_step_d;
                        drain_q   <= 2'd0;
                    end else begin
                        rd_addr_a_q <= pair_j_d;
                        rd_addr_b_q <= pair_j_d + len_q;
                        twiddle_q   <= pair_k_d;
                        cnt_q       <= cnt_q + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        if (layer_q == last_layer_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Last write of the previous layer has landed
                            state_q     <= ST_ISSUE;
                            layer_q     <= layer_q + 3'd1;
                            rd_en_q     <= 1'b1;
                            rd_addr_a_q <= 8'd0;
                            rd_addr_b_q <= len_q;
                            cnt_q       <= 8'd1;
                        end
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef NTT_CTRL_OUT_REG_EN
    // Write-back pipeline, two stages: read -> butterfly -> output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr1_en_q     <= 1'b0;
            wr1_addr_a_q <= 8'd0;
            wr1_addr_b_q <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_addr_a_q  <= 8'd0;
            wr_addr_b_q  <= 8'd0;
        end else begin
            wr1_en_q     <= rd_en_q;
            wr1_addr_a_q <= rd_addr_a_q;
            wr1_addr_b_q <= rd_addr_b_q;
            wr_en_q      <= wr1_en_q;
            wr_addr_a_q  <= wr1_addr_a_q;
            wr_addr_b_q  <= wr1_addr_b_q;
        end
    end
`else
    // Write-back pipeline, one stage matching the butterfly latency
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= 8'd0;
            wr_addr_b_q <= 8'd0;
        end else begin
            wr_en_q     <= rd_en_q;
            wr_addr_a_q <= rd_addr_a_q;
            wr_addr_b_q <= rd_addr_b_q;
        end
    end
`endif

    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;
    assign bus.rd_en_o         = rd_en_q;
    assign bus.rd_addr_a_o     = rd_addr_a_q;
    assign bus.rd_addr_b_o     = rd_addr_b_q;
    assign bus.twiddle_idx_o   = twiddle_q;
    assign bus.wr_en_o         = wr_en_q;
    assign bus.wr_addr_a_o     = wr_addr_a_q;
    assign bus.wr_addr_b_o     = wr_addr_b_q;
    assign bus.sel_red_o       = sel_red_q;
    assign bus.sel_butterfly_o = sel_butterfly_q;

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_i, input, 1, synchronous active-high reset.
REQ-003 SHALL have start_i, input, 1, one-cycle request to begin a transform; sampled only in IDLE.
REQ-004 SHALL have sel_red_i, input, 1, parameter set sampled with start_i (1 = Kyber q=3329, 7 layers; 0 = Dilithium q=8380417, 8 layers).
REQ-005 SHALL have sel_butterfly_i, input, 1, direction sampled with start_i (0 = forward Cooley-Tukey, 1 = inverse Gentleman-Sande).
REQ-006 SHALL have busy_o, output, 1, high while a transform is in progress.
REQ-007 SHALL have done_o, output, 1, one-cycle pulse on transform completion.
REQ-008 SHALL have rd_en_o, rd_addr_a_o[7:0] and rd_addr_b_o[7:0] as outputs: coefficient-pair read request to a 1-cycle-latency dual-read memory.
REQ-009 SHALL have twiddle_idx_o[7:0], output, twiddle ROM index issued in the same cycle as the matching read.
REQ-010 SHALL have wr_en_o, wr_addr_a_o[7:0] and wr_addr_b_o[7:0] as outputs: write-back of butterfly results.
REQ-011 SHALL have sel_red_o and sel_butterfly_o, outputs, 1 each, latched mode bits driven to the butterfly for the whole transform.

Function
REQ-012 SHALL implement states IDLE, ISSUE, DRAIN and DONE. Transitions: IDLE->ISSUE on start_i; ISSUE->DRAIN after the 128th pair of a layer; DRAIN->ISSUE after D cycles if layers remain, else DRAIN->DONE; DONE->IDLE after one cycle.
REQ-013 SHALL issue exactly one butterfly pair per ISSUE cycle (rd_en_o=1), 128 pairs per layer, with rd_addr_a_o=j and rd_addr_b_o=j+len.
REQ-014 SHALL order the loops as: for each layer, start=0 stepping by 2*len up to 255; within each group, j=start..start+len-1.
REQ-015 Forward: len SHALL take 128,64,...,2 for Kyber and 128,...,1 for Dilithium.
REQ-016 Inverse: len SHALL take 2,...,128 for Kyber and 1,...,128 for Dilithium.
REQ-017 Twiddle index SHALL change once per group, constant within the group.
REQ-018 Forward: k starts at 1 and increments per group (Kyber ends at 127, Dilithium at 255).
REQ-019 Inverse: k starts at 127 (Kyber) or 255 (Dilithium) and decrements per group, ending at 1.
REQ-020 wr_en_o and wr_addr_a/b_o SHALL equal rd_en_o and rd_addr_a/b_o delayed by D cycles; D=1 by default.
REQ-021 DRAIN SHALL last D cycles so that no read of layer L+1 precedes the last write of layer L.
REQ-022 busy_o SHALL be high from the cycle after start_i is accepted through the DONE cycle; done_o SHALL be high only in DONE.
REQ-023 Total latency from start_i to done_o SHALL be layers*(128+D)+1 cycles.
REQ-024 start_i while not in IDLE SHALL be ignored; sel_red_i and sel_butterfly_i changes during a transform SHALL have no effect.
REQ-025 Address arithmetic SHALL be 8-bit unsigned; j+len never exceeds 255 by construction.
REQ-026 Final n^-1 scaling SHALL NOT be performed by this block.

Reset
REQ-027 rst_i SHALL force IDLE and drive every output to 0 on the next edge, including mid-transform; the delay pipeline SHALL also clear, so no write occurs after reset.

Configuration
REQ-028 With macro NTT_CTRL_OUT_REG_EN defined, D SHALL be 2 (a registered butterfly output stage) and the added write-pipeline stage SHALL exist. Without the macro, D SHALL be 1.

Verification
REQ-029 Kyber forward (sel_red_i=1, sel_butterfly_i=0), D=1: first issue (0,128) with tw=1; layer 2 issues (0,64) tw=2, then (128,192) tw=3; last pair (253,255) tw=127; done_o at cycle 904.
REQ-030 Dilithium forward: last layer pairs (0,1) tw=128 through (254,255) tw=255; done_o at cycle 8*129+1=1033.
REQ-031 Kyber inverse: first issues (0,2) tw=127 and (1,3) tw=127, then (4,6) tw=126; final layer (0,128) tw=1.
REQ-032 Write pipeline with NTT_CTRL_OUT_REG_EN defined and undefined: each wr_addr equals the rd_addr from 2 (resp. 1) cycles earlier, and no read of a layer occurs before the prior layer's last write.
REQ-033 Reset and start filtering: rst_i asserted at cycle 300 of a transform gives all outputs 0 next cycle and no wr_en_o afterwards; start_i pulses while busy_o=1 are ignored.
